// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among NREQ requesters with a req/ack handshake.
// Define REGARB_RR_EN for round-robin arbitration; otherwise the lowest index wins.
module regfile_write_arbiter #(
    parameter int NREQ = 3,
    parameter int DW   = 4,
    parameter int AW   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_data,
    output logic [NREQ-1:0]      ack,
    output logic [(2**AW)-1:0]   chosen,
    output logic                 w_en,
    output logic [DW-1:0]        w_data,
    output logic                 busy,
    output logic                 err
);

    localparam int NR = 2 ** AW;
    localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    state_t          state;
    logic [LW-1:0]   win;
    logic [NREQ-1:0] req_q;
    logic [NREQ-1:0] ack_q;
    logic            req_x;
    logic            withdrawn;
    logic [AW-1:0]   addr_a [NREQ];
    logic [DW-1:0]   data_a [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_unpack
        assign addr_a[i] = req_addr[i*AW +: AW];
        assign data_a[i] = req_data[i*DW +: DW];
    end

`ifdef REGARB_RR_EN
    logic [LW-1:0] last;

    // Search starts just past the previous winner and wraps.
    always_comb begin
        int   idx;
        logic found;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int j = 1; j <= NREQ; j++) begin
            idx = int'(last) + j;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!found && req[LW'(idx)]) begin
                found = 1'b1;
                win   = LW'(idx);
            end
        end
    end
`else
    always_comb begin
        win = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[LW'(i)]) win = LW'(i);
        end
    end
`endif

    assign req_x     = ((^req) === 1'bx);
    assign withdrawn = |(req_q & ~req & ~ack_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            ack    <= '0;
            chosen <= '0;
            w_en   <= 1'b0;
            w_data <= '0;
            busy   <= 1'b0;
            err    <= 1'b0;
            req_q  <= '0;
            ack_q  <= '0;
`ifdef REGARB_RR_EN
            last   <= LW'(NREQ - 1);
`endif
        end else begin
            req_q <= req;
            ack_q <= ack;
            if (withdrawn || (state == IDLE && req_x)) err <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (|req) begin
                        state  <= ISSUE;
                        ack    <= NREQ'(1) << win;
                        chosen <= NR'(1) << addr_a[win];
                        w_en   <= 1'b1;
                        w_data <= data_a[win];
                        busy   <= 1'b1;
`ifdef REGARB_RR_EN
                        last   <= win;
`endif
                    end
                end
                ISSUE: begin
                    state  <= IDLE;
                    ack    <= '0;
                    chosen <= '0;
                    w_en   <= 1'b0;
                    w_data <= '0;
                    busy   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized and directed bench for regfile_write_arbiter with a behavioural model.
// Follows REGARB_RR_EN the same way the design does.
module tb_regfile_write_arbiter;

    localparam int NREQ = 3;
    localparam int DW   = 4;
    localparam int AW   = 2;
    localparam int NR   = 4;

    logic                clk = 1'b0;
    logic                rst = 1'b0;
    logic [NREQ-1:0]     r_req = '0;
    logic [AW-1:0]       r_addr [NREQ];
    logic [DW-1:0]       r_data [NREQ];
    logic [NREQ*AW-1:0]  req_addr;
    logic [NREQ*DW-1:0]  req_data;
    logic [NREQ-1:0]     ack;
    logic [NR-1:0]       chosen;
    logic                w_en;
    logic [DW-1:0]       w_data;
    logic                busy;
    logic                err;

    int n_vec = 0;
    int n_bad = 0;
    bit auto_mode = 1'b0;
    logic [NREQ-1:0] ack_seen = '0;

    // Model state: expected outputs plus what the rules need to remember.
    logic [NREQ-1:0] m_ack, p_req, p_ack;
    logic [NR-1:0]   m_chosen;
    logic            m_wen, m_busy, m_err;
    logic [DW-1:0]   m_wdata;
    int              m_last;
    bit              m_issue;

    always #5 clk = ~clk;

    always_comb begin
        req_addr = '0;
        req_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*AW +: AW] = r_addr[i];
            req_data[i*DW +: DW] = r_data[i];
        end
    end

    regfile_write_arbiter #(.NREQ(NREQ), .DW(DW), .AW(AW)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (r_req),
        .req_addr(req_addr),
        .req_data(req_data),
        .ack     (ack),
        .chosen  (chosen),
        .w_en    (w_en),
        .w_data  (w_data),
        .busy    (busy),
        .err     (err)
    );

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_ack = '0; m_chosen = '0; m_wen = 1'b0; m_wdata = '0;
        m_busy = 1'b0; m_err = 1'b0; m_issue = 1'b0;
        p_req = '0; p_ack = '0;
        m_last = NREQ - 1;
    endfunction

    function automatic void model_step();
        int w;
        if (|(p_req & ~r_req & ~p_ack)) m_err = 1'b1;
        p_req = r_req;
        p_ack = m_ack;
        m_ack = '0; m_chosen = '0; m_wen = 1'b0; m_wdata = '0; m_busy = 1'b0;
        if (m_issue) begin
            m_issue = 1'b0;
        end else if (r_req != '0) begin
            w = -1;
`ifdef REGARB_RR_EN
            for (int j = 1; j <= NREQ; j++) begin
                int k;
                k = (m_last + j) % NREQ;
                if (w < 0 && r_req[k]) w = k;
            end
`else
            for (int k = 0; k < NREQ; k++) begin
                if (w < 0 && r_req[k]) w = k;
            end
`endif
            m_last = w;
            m_ack[w] = 1'b1;
            m_chosen[r_addr[w]] = 1'b1;
            m_wen = 1'b1;
            m_wdata = r_data[w];
            m_busy = 1'b1;
            m_issue = 1'b1;
        end
    endfunction

    task automatic new_req(input int i);
        r_req[i]  = 1'b1;
        r_addr[i] = AW'($urandom_range(NR - 1, 0));
        r_data[i] = DW'($urandom);
    endtask

    task automatic rand_update();
        for (int i = 0; i < NREQ; i++) begin
            if (ack_seen[i]) begin
                if ($urandom_range(1, 0) == 1) new_req(i);
                else r_req[i] = 1'b0;
            end else if (!r_req[i] && $urandom_range(9, 0) < 3) begin
                new_req(i);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (!rst) model_step();
        #1;
        if (auto_mode) rand_update();
    endtask

    task automatic hold_release();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        model_reset();
        hold_release();
    endtask

    function automatic int onehot_idx(input logic [NREQ-1:0] v);
        int r;
        r = -1;
        for (int i = 0; i < NREQ; i++) if (v[i]) r = i;
        return r;
    endfunction

    // One compare per cycle against the model.
    always @(negedge clk) begin
        ack_seen = ack;
        chk("outputs", {18'd0, ack, chosen, w_en, w_data, busy, err},
            {18'd0, m_ack, m_chosen, m_wen, m_wdata, m_busy, m_err});
    end

    initial begin
        int g [4];
        int gc [4];
        int n;
        int exp_g [4];
        int w;
`ifdef REGARB_RR_EN
        exp_g = '{0, 1, 2, 0};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        for (int i = 0; i < NREQ; i++) begin
            r_addr[i] = '0;
            r_data[i] = '0;
        end
        model_reset();
        #1;
        do_reset();
        chk("reset_state", {ack, chosen, w_en, w_data, busy, err}, 14'd0);

        // Single request from requester 1 to register 3.
        r_req = 3'b010; r_addr[1] = 2'd3; r_data[1] = 4'hA;
        step();
        chk("single_ack", ack, 3'b010);
        chk("single_wen", w_en, 1'b1);
        chk("single_chosen", chosen, 4'b1000);
        chk("single_wdata", w_data, 4'hA);
        chk("single_busy", busy, 1'b1);
        step();
        r_req = '0;
        chk("single_after", {ack, chosen, w_en, w_data, busy}, 13'd0);
        step();
        chk("single_noerr", err, 1'b0);

        // All three requesting continuously.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin
            r_addr[i] = AW'(i);
            r_data[i] = DW'(i + 1);
        end
        r_req = 3'b111;
        g = '{-1, -1, -1, -1};
        gc = '{0, 0, 0, 0};
        n = 0;
        for (int c = 0; c < 20 && n < 4; c++) begin
            step();
            if (ack != '0) begin
                g[n] = onehot_idx(ack);
                gc[n] = c;
                n++;
            end
        end
        chk("fair_count", n, 4);
        for (int k = 0; k < 4; k++) chk("fair_grant", g[k], exp_g[k]);
        for (int k = 1; k < 4; k++) chk("fair_gap", gc[k] - gc[k-1], 2);
        step();
        r_req[0] = 1'b0;
        w = -1;
        for (int c = 0; c < 6 && w < 0; c++) begin
            step();
            if (ack != '0) w = onehot_idx(ack);
        end
        chk("after_drop0", w, 1);
        step();
        r_req = '0;
        step();

        // Requester 2 withdraws before being served.
        do_reset();
        r_req = 3'b001; r_addr[0] = 2'd0; r_data[0] = 4'h5;
        step();
        chk("err_issue0", ack, 3'b001);
        r_req[2] = 1'b1; r_addr[2] = 2'd2; r_data[2] = 4'h7;
        step();
        r_req = '0;
        chk("err_before", err, 1'b0);
        step();
        chk("err_set", err, 1'b1);
        step();
        step();
        step();
        chk("err_sticky", err, 1'b1);
        do_reset();
        chk("err_cleared", err, 1'b0);

        // Reset lands during the ISSUE cycle.
        for (int i = 0; i < NREQ; i++) begin
            r_addr[i] = AW'(NR - 1 - i);
            r_data[i] = DW'(4'hC + i);
        end
        r_req = 3'b111;
        step();
        chk("midrst_issue", w_en, 1'b1);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst_zero", {ack, chosen, w_en, busy}, 10'd0);
        hold_release();
        step();
        chk("midrst_first", ack, 3'b001);
        step();
        r_req = '0;
        step();

        // Randomized traffic with protocol-respecting requesters.
        do_reset();
        auto_mode = 1'b1;
        for (int c = 0; c < 600; c++) step();
        auto_mode = 1'b0;
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the CPU's 4 x 4-bit register file between several write requesters (ALU writeback, load unit, I/O unit) using a req/ack handshake. Each winning request is turned into one cycle of one-hot register select `chosen`, `w_en` and `w_data`, which drive every register's write inputs directly. The block sits between the execution units and the register file and owns all register write sequencing.

## Interface

Parameters:
- `NREQ`, 3: number of requesters; index 0 to NREQ-1.
- `DW`, 4: register data width.
- `AW`, 2: register address width; register count is fixed at 2**AW.

Ports:
- `clk`  input  1  system clock, all state updates on the rising edge.
- `rst`  input  1  reset. One clock; reset is asynchronous and active-high.
- `req`  input  NREQ  per-requester write request, level, held until acked.
- `req_addr`  input  NREQ*AW  packed target register addresses; requester i occupies bits [i*AW +: AW].
- `req_data`  input  NREQ*DW  packed write data; requester i occupies bits [i*DW +: DW].
- `ack`  output  NREQ  one-hot, one-cycle pulse marking the cycle in which requester i's write is performed.
- `chosen`  output  2**AW  one-hot register select, decoded from the winner's address.
- `w_en`  output  1  register file write enable.
- `w_data`  output  DW  write data to the register file.
- `busy`  output  1  high while in ISSUE.
- `err`  output  1  sticky protocol-violation flag.

## Operation

- FSM with two states, IDLE and ISSUE. Reset state is IDLE.
- In IDLE with `req` != 0:
  - pick a winner;
  - latch its address into the decoded `chosen` register and its data into `w_data`;
  - set `ack[winner]` and `w_en`;
  - go to ISSUE.
- In IDLE with `req` == 0: stay in IDLE; all outputs 0.
- ISSUE lasts exactly one cycle. During it `w_en` = 1, exactly one bit of `chosen` and of `ack` is set, and `busy` = 1. Next state is always IDLE, where `w_en`, `chosen` and `ack` return to 0.
- Requester rules:
  - `req`, `req_addr` and `req_data` are held stable from assertion until the clock edge that ends the `ack` cycle.
  - `req` is dropped after that edge unless the requester has another write pending.
- Sampling is done only in IDLE, so a requester that keeps `req` high after ack is treated as a new request.
- Arbitration is round-robin (see Configuration):
  - A pointer `last` holds the most recent winner; reset value is NREQ-1.
  - The search starts at (`last`+1) mod NREQ and wraps past NREQ-1 to 0. The first set `req` bit wins.
  - `last` updates to the winner on entry to ISSUE.
- Address decode: `chosen[k]` = 1 iff the latched addr = k. Every address is in range by construction.
- Error flag `err`:
  - set when, for any i, `req[i]` was 1 in the previous cycle, is 0 now, and `ack[i]` was not 1 in the previous cycle (request withdrawn before service);
  - also set if `req` has an X/Z bit while in IDLE (simulation check, via `===`);
  - cleared only by `rst`.
- Reset (asserted at any time, including mid-ISSUE): immediately forces IDLE, `last` = NREQ-1, and all outputs to 0. A write in progress is abandoned and no ack is delivered.

## Timing

- Reset values: `ack` = 0, `chosen` = 0, `w_en` = 0, `w_data` = 0, `busy` = 0, `err` = 0.
- Latency: `req` sampled high at edge E0 gives `ack`/`w_en` high from E0 to E1. The register file captures `w_data` at E1.
- Throughput: at most one write every 2 cycles. With continuous requests the pattern is ISSUE, IDLE, ISSUE, and so on.
- All outputs are registered. There is no combinational path from `req` to any output.

## Configuration

- `REGARB_RR_EN` defined: round-robin arbitration as described above.
- `REGARB_RR_EN` undefined:
  - fixed priority; the lowest index wins;
  - `last` is not implemented;
  - every other behaviour is identical.

## Test plan

- Single request: after reset, req = 3'b010, req_addr[3:2] = 2'd3, req_data[7:4] = 4'hA. Required: after the next edge, ack = 3'b010, w_en = 1, chosen = 4'b1000, w_data = 4'hA for exactly one cycle; then all 0.
- Round-robin fairness (`REGARB_RR_EN`): req = 3'b111 held, each requester re-requesting after its ack. Required: grants in order 0, 1, 2, 0, with ack pulses 2 cycles apart.
- Fixed priority (macro undefined): same stimulus as round-robin fairness. Required: requester 0 wins every time while it keeps requesting; 1 and 2 win only after req[0] drops.
- Protocol error: req[2] = 1 for one cycle, then dropped before any ack (e.g. while ISSUE serves requester 0). Required: err = 1 next cycle and stays 1 until rst.
- Reset mid-write: assert rst during the ISSUE cycle. Required: w_en, ack, chosen and busy go to 0 immediately. After release with req = 3'b111, the first grant goes to requester 0.
